bandai_eeprom_ctrl: RTL and testbench

Cartridge serial-EEPROM sequencer behind the mapper's I/O window at ports C4h–C8h. The parent decodes the port and presents a 3-bit register index. Host software loads a command word and, for writes, a data word, then triggers READ, WRITE or SHORT. The block drives a 93Cxx Microwire EEPROM (CS/SK/DI/DO) through the full transaction and reports completion in a status register. It is the only agent that touches the EEPROM pins.

---
 rtl/bandai_eeprom_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_bandai_eeprom_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bandai_eeprom_ctrl.sv
// Microwire (93Cxx) EEPROM sequencer behind a byte-wide register window.
// Host loads ADDR/DATA, triggers READ/WRITE/SHORT; the FSM runs the full frame.
module bandai_eeprom_ctrl #(
  parameter int ADDR_BITS = 6,
  parameter int CLK_DIV   = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [2:0] REG_SEL,
  input  logic       REG_WR,
  input  logic [7:0] REG_WDATA,
  output logic [7:0] REG_RDATA,
  output logic       BUSY,
  output logic       EE_CS,
  output logic       EE_SK,
  output logic       EE_DI,
  input  logic       EE_DO
);
  localparam int CW_W    = 3 + ADDR_BITS;
  localparam int SLOT_W  = 2 * CLK_DIV;
  localparam int CNT_W   = $clog2(SLOT_W) + 1;
  localparam int SLOTN_W = $clog2((CW_W > 16) ? CW_W : 16) + 1;
  localparam int POLL_W  = $clog2(TIMEOUT) + 1;

  localparam logic [CNT_W-1:0]   HALF_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]   HALF      = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0]   SLOT_LAST = CNT_W'(SLOT_W - 1);
  localparam logic [SLOTN_W-1:0] CW_LAST   = SLOTN_W'(CW_W - 1);
  localparam logic [SLOTN_W-1:0] WORD_LAST = SLOTN_W'(15);
  localparam logic [POLL_W-1:0]  POLL_LAST = POLL_W'(TIMEOUT - 1);
  localparam logic [CW_W-1:0]    CW_MSB    = {1'b1, {(CW_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_CSSETUP, S_CMD, S_DIN, S_DOUT, S_CSGAP, S_POLL, S_END
  } state_t;

  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_SHORT} op_t;

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [SLOTN_W-1:0]   r_slot, w_slot_nxt;
  logic [POLL_W-1:0]    r_poll, w_poll_nxt;
  op_t                  r_op;
  logic [15:0]          r_data;
  logic [15:0]          r_addr;
  logic [14:0]          r_shadow;
  logic [3:0]           r_status;
  logic                 r_busy;
  logic                 r_cs, r_sk, r_di;

  logic                 w_accept;
  logic                 w_slot_end;
  logic                 w_sample, w_commit, w_timeout, w_finish;
  logic                 w_cs_nxt, w_sk_nxt, w_di_nxt;
  logic [CW_W-1:0]      w_cw;

  assign w_cw       = {1'b1, r_addr[ADDR_BITS+1:0]};
  assign w_slot_end = (r_cnt == SLOT_LAST);
  assign w_accept   = REG_WR && (REG_SEL == 3'd4) && !r_busy && $onehot(REG_WDATA[6:4]);

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_slot_nxt  = r_slot;
    w_poll_nxt  = r_poll;
    w_sample    = 1'b0;
    w_commit    = 1'b0;
    w_timeout   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      // One launch cycle in IDLE with BUSY already high before CS rises.
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (r_busy) w_state_nxt = S_CSSETUP;
      end
      S_CSSETUP: if (r_cnt == HALF_LAST) begin
        w_state_nxt = S_CMD;
        w_cnt_nxt   = '0;
        w_slot_nxt  = '0;
      end
      S_CMD: if (w_slot_end) begin
        w_cnt_nxt  = '0;
        w_slot_nxt = r_slot + 1'b1;
        if (r_slot == CW_LAST) begin
          w_slot_nxt = '0;
          case (r_op)
            OP_READ:  w_state_nxt = S_DIN;
            OP_WRITE: w_state_nxt = S_DOUT;
            default:  w_state_nxt = S_END;
          endcase
        end
      end
      S_DIN: if (w_slot_end) begin
        w_sample   = 1'b1;
        w_cnt_nxt  = '0;
        w_slot_nxt = r_slot + 1'b1;
        if (r_slot == WORD_LAST) begin
          w_commit    = 1'b1;
          w_slot_nxt  = '0;
          w_state_nxt = S_END;
        end
      end
      S_DOUT: if (w_slot_end) begin
        w_cnt_nxt  = '0;
        w_slot_nxt = r_slot + 1'b1;
        if (r_slot == WORD_LAST) begin
          w_slot_nxt  = '0;
          w_state_nxt = S_CSGAP;
        end
      end
      S_CSGAP: if (r_cnt == SLOT_LAST) begin
        w_state_nxt = S_POLL;
        w_cnt_nxt   = '0;
        w_poll_nxt  = '0;
      end
      S_POLL: if (w_slot_end) begin
        w_cnt_nxt  = '0;
        w_poll_nxt = r_poll + 1'b1;
        if (EE_DO) begin
          w_state_nxt = S_END;
        end else if (r_poll == POLL_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_END;
        end
      end
      S_END: if (r_cnt == HALF_LAST) begin
        w_finish    = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pins are registered from next-state values so they never glitch.
  always_comb begin
    w_cs_nxt = (w_state_nxt == S_CSSETUP) || (w_state_nxt == S_CMD) ||
               (w_state_nxt == S_DIN) || (w_state_nxt == S_DOUT) || (w_state_nxt == S_POLL);
    w_sk_nxt = ((w_state_nxt == S_CMD) || (w_state_nxt == S_DIN) ||
                (w_state_nxt == S_DOUT) || (w_state_nxt == S_POLL)) && (w_cnt_nxt >= HALF);
    w_di_nxt = 1'b0;
    if (w_state_nxt == S_CMD)
      w_di_nxt = |(w_cw & (CW_MSB >> w_slot_nxt));
    else if (w_state_nxt == S_DOUT)
      w_di_nxt = |(r_data & (16'h8000 >> w_slot_nxt));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_slot   <= '0;
      r_poll   <= '0;
      r_op     <= OP_READ;
      r_data   <= '0;
      r_addr   <= '0;
      r_shadow <= '0;
      r_status <= '0;
      r_busy   <= 1'b0;
      r_cs     <= 1'b0;
      r_sk     <= 1'b0;
      r_di     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_slot  <= w_slot_nxt;
      r_poll  <= w_poll_nxt;
      r_cs    <= w_cs_nxt;
      r_sk    <= w_sk_nxt;
      r_di    <= w_di_nxt;

      if (REG_WR && !r_busy) begin
        case (REG_SEL)
          3'd0:    r_data[7:0]  <= REG_WDATA;
          3'd1:    r_data[15:8] <= REG_WDATA;
          3'd2:    r_addr[7:0]  <= REG_WDATA;
          3'd3:    r_addr[15:8] <= REG_WDATA;
          default: ;
        endcase
      end

      if (w_accept) begin
        r_busy   <= 1'b1;
        r_status <= '0;
        r_op     <= REG_WDATA[4] ? OP_READ : (REG_WDATA[5] ? OP_WRITE : OP_SHORT);
      end

      if (w_sample) r_shadow <= {r_shadow[13:0], EE_DO};
      if (w_commit) r_data   <= {r_shadow, EE_DO};
      if (w_timeout) r_status[3] <= 1'b1;

      if (w_finish) begin
        r_busy <= 1'b0;
        case (r_op)
          OP_READ:  r_status[0] <= 1'b1;
          OP_WRITE: r_status[1] <= 1'b1;
          default:  r_status[2] <= 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    case (REG_SEL)
      3'd0:    REG_RDATA = r_data[7:0];
      3'd1:    REG_RDATA = r_data[15:8];
      3'd2:    REG_RDATA = r_addr[7:0];
      3'd3:    REG_RDATA = r_addr[15:8];
      3'd4:    REG_RDATA = {r_busy, 3'b000, r_status};
      default: REG_RDATA = 8'hFF;
    endcase
  end

  assign BUSY  = r_busy;
  assign EE_CS = r_cs;
  assign EE_SK = r_sk;
  assign EE_DI = r_di;

endmodule

// File: tb/tb_bandai_eeprom_ctrl.sv
// Directed bench for bandai_eeprom_ctrl: a pin-level 93Cxx model plus a
// second instance with a short ready-poll limit for the timeout case.
module tb_bandai_eeprom_ctrl;
  localparam int CW_W = 9;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic [2:0] REG_SEL;
  logic       REG_WR, REG_WR2;
  logic [7:0] REG_WDATA;
  logic [7:0] rdata1, rdata2;
  logic       busy1, busy2;
  logic       ee_cs, ee_sk, ee_di, ee_do;
  logic       cs2, sk2, di2;
  wire        do2 = 1'b0;

  bandai_eeprom_ctrl u_dut (
    .CLK(CLK), .RSTn(RSTn), .REG_SEL(REG_SEL), .REG_WR(REG_WR),
    .REG_WDATA(REG_WDATA), .REG_RDATA(rdata1), .BUSY(busy1),
    .EE_CS(ee_cs), .EE_SK(ee_sk), .EE_DI(ee_di), .EE_DO(ee_do)
  );

  bandai_eeprom_ctrl #(.TIMEOUT(8)) u_dut_to (
    .CLK(CLK), .RSTn(RSTn), .REG_SEL(REG_SEL), .REG_WR(REG_WR2),
    .REG_WDATA(REG_WDATA), .REG_RDATA(rdata2), .BUSY(busy2),
    .EE_CS(cs2), .EE_SK(sk2), .EE_DI(di2), .EE_DO(do2)
  );

  always #5 CLK = ~CLK;

  int tick = 0;
  always @(posedge CLK) tick <= tick + 1;

  // Model configuration, written by the stimulus only.
  logic        model_clr = 1'b1;
  logic        model_read = 1'b0;
  logic [15:0] rd_word = 16'h0;
  int          poll_ready_at = 0;

  // Model state, written by the monitors only.
  int          sess = 0, mon_k = 0, di_n = 0, gap_cnt = 0, poll_k = 0, viol = 0;
  logic [63:0] di_cap = '0;
  logic        prev_cs = 1'b0, prev_sk = 1'b0, prev_di = 1'b0;
  int          sess2 = 0, poll2 = 0;
  logic        prev_cs2 = 1'b0, prev_sk2 = 1'b0;

  always @(negedge CLK) begin
    if (model_clr) begin
      sess = 0; mon_k = 0; di_n = 0; gap_cnt = 0; poll_k = 0; ee_do = 1'b0;
    end else begin
      if ((ee_sk && !ee_cs) ||
          (ee_cs && !prev_cs && (ee_sk !== prev_sk || ee_di !== prev_di)))
        viol++;
      if (ee_cs && !prev_cs) begin
        sess++;
        mon_k = 0;
      end
      if (!ee_cs && prev_cs) ee_do = 1'b0;
      if (!ee_cs && sess == 1) gap_cnt++;
      if (ee_cs && ee_sk && !prev_sk) begin
        if (sess == 1) begin
          if (di_n < 64) di_cap[di_n] = ee_di;
          di_n++;
          ee_do = (model_read && mon_k >= CW_W && mon_k < CW_W + 16) ? rd_word[24 - mon_k] : 1'b0;
        end else begin
          ee_do  = (mon_k >= poll_ready_at);
          poll_k = mon_k + 1;
        end
        mon_k++;
      end
    end
    prev_cs = ee_cs;
    prev_sk = ee_sk;
    prev_di = ee_di;
  end

  always @(negedge CLK) begin
    if (model_clr) begin
      sess2 = 0; poll2 = 0;
    end else begin
      if (cs2 && !prev_cs2) sess2++;
      if (cs2 && sk2 && !prev_sk2 && sess2 == 2) poll2++;
    end
    prev_cs2 = cs2;
    prev_sk2 = sk2;
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] sel, input logic [7:0] d);
    REG_SEL = sel; REG_WDATA = d; REG_WR = 1'b1;
    @(negedge CLK);
    REG_WR = 1'b0;
  endtask

  task automatic wr2(input logic [2:0] sel, input logic [7:0] d);
    REG_SEL = sel; REG_WDATA = d; REG_WR2 = 1'b1;
    @(negedge CLK);
    REG_WR2 = 1'b0;
  endtask

  task automatic rd(input logic [2:0] sel, output logic [31:0] v);
    REG_SEL = sel;
    #1;
    v = 32'(rdata1);
  endtask

  task automatic rd2(input logic [2:0] sel, output logic [31:0] v);
    REG_SEL = sel;
    #1;
    v = 32'(rdata2);
  endtask

  task automatic clr_model();
    model_clr = 1'b1;
    @(negedge CLK);
    #1 model_clr = 1'b0;
  endtask

  // Cycles from the call (first cycle after the accepting edge) until BUSY reads low.
  task automatic wait_idle(input bit which, output int dt);
    int t0, n;
    t0 = tick;
    n  = 0;
    while (((which ? busy2 : busy1) === 1'b1) && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    dt = tick - t0;
  endtask

  function automatic logic [31:0] bits(input int start, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[30:0], di_cap[start + i]};
    return v;
  endfunction

  initial begin
    logic [31:0] v;
    int dt, t_start, k_hold, n;

    RSTn = 1'b0; REG_SEL = 3'd0; REG_WR = 1'b0; REG_WR2 = 1'b0; REG_WDATA = 8'h00;

    // Reset state
    @(negedge CLK);
    for (int i = 0; i < 5; i++) begin
      rd(3'(i), v);
      check($sformatf("reset_reg%0d", i), v, 32'h00);
    end
    rd(3'd5, v);
    check("reset_unused_ff", v, 32'hFF);
    check("reset_pins", {29'b0, ee_cs, ee_sk, ee_di}, 32'h0);
    check("reset_busy", 32'(busy1), 32'h0);
    RSTn = 1'b1;
    clr_model();

    // READ 0x85 -> model returns BEEF
    model_read = 1'b1; rd_word = 16'hBEEF;
    wr(3'd2, 8'h85);
    wr(3'd4, 8'h10);
    wait_idle(1'b0, dt);
    check("read_latency", 32'(dt), 32'd209);
    check("read_frame", bits(0, 9), 32'b1_1000_0101);
    check("read_sessions", 32'(sess), 32'd1);
    check("read_slots", 32'(di_n), 32'd25);
    check("read_viol", 32'(viol), 32'd0);
    rd(3'd1, v); check("read_data_hi", v, 32'hBE);
    rd(3'd0, v); check("read_data_lo", v, 32'hEF);
    rd(3'd4, v); check("read_status", v, 32'h01);

    // WRITE 0x45 <- 1234, ready after 10 busy polls
    clr_model();
    model_read = 1'b0; poll_ready_at = 10;
    wr(3'd2, 8'h45);
    wr(3'd0, 8'h34);
    wr(3'd1, 8'h12);
    wr(3'd4, 8'h20);
    wait_idle(1'b0, dt);
    check("write_frame", bits(0, 9), 32'b1_0100_0101);
    check("write_data_bits", bits(9, 16), 32'h1234);
    check("write_slots", 32'(di_n), 32'd25);
    check("write_cs_gap", 32'(gap_cnt), 32'd8);
    check("write_sessions", 32'(sess), 32'd2);
    check("write_poll_samples", 32'(poll_k), 32'd11);
    rd(3'd4, v); check("write_status", v, 32'h02);

    // SHORT EWEN
    clr_model();
    wr(3'd2, 8'h30);
    wr(3'd4, 8'h40);
    wait_idle(1'b0, dt);
    check("short_latency", 32'(dt), 32'd81);
    check("short_frame", bits(0, 9), 32'b1_0011_0000);
    check("short_slots", 32'(di_n), 32'd9);
    check("short_sessions", 32'(sess), 32'd1);
    rd(3'd4, v); check("short_status", v, 32'h04);

    // Rejected CTRL writes
    wr(3'd4, 8'h30);
    check("rej_multi_busy", 32'(busy1), 32'h0);
    rd(3'd4, v); check("rej_multi_status", v, 32'h04);
    wr(3'd4, 8'h00);
    check("rej_zero_busy", 32'(busy1), 32'h0);
    rd(3'd4, v); check("rej_zero_status", v, 32'h04);

    // Writes while busy are ignored
    clr_model();
    model_read = 1'b1; rd_word = 16'hA5C3;
    wr(3'd4, 8'h10);
    t_start = tick;
    wr(3'd0, 8'h55);
    wr(3'd4, 8'h10);
    wr(3'd4, 8'h20);
    rd(3'd4, v); check("busy_status", v, 32'h80);
    wait_idle(1'b0, dt);
    check("busy_latency", 32'(tick - t_start), 32'd209);
    check("busy_sessions", 32'(sess), 32'd1);
    rd(3'd4, v); check("busy_final_status", v, 32'h01);
    rd(3'd0, v); check("busy_data_lo", v, 32'hC3);
    rd(3'd1, v); check("busy_data_hi", v, 32'hA5);

    // Timeout instance: DO stuck low
    clr_model();
    wr2(3'd2, 8'h45);
    wr2(3'd4, 8'h20);
    wait_idle(1'b1, dt);
    check("to_poll_samples", 32'(poll2), 32'd8);
    rd2(3'd4, v); check("to_status", v, 32'h0A);

    // Reset in the middle of a READ
    clr_model();
    rd_word = 16'hBEEF;
    wr(3'd4, 8'h10);
    n = 0;
    while (mon_k < 13 && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    check("rst_reached_slot12", 32'(mon_k >= 13), 32'd1);
    RSTn = 1'b0;
    @(negedge CLK);
    check("rst_cs", 32'(ee_cs), 32'd0);
    check("rst_sk", 32'(ee_sk), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    rd(3'd0, v); check("rst_data_lo", v, 32'h00);
    rd(3'd1, v); check("rst_data_hi", v, 32'h00);
    RSTn = 1'b1;
    k_hold = mon_k;
    repeat (20) @(negedge CLK);
    check("rst_no_sk_after", 32'(mon_k), 32'(k_hold));
    check("pin_rules", 32'(viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
